// File: rtl/ysyx_25020047_ifu.sv
// ysyx_25020047_ifu: instruction fetch unit, one outstanding imem read, valid/ready handoff to IDU.
// Optional feature macro: IFU_MISALIGN_CHECK_EN (sticky misaligned-redirect trap and fetch lock).
`default_nettype none

module ysyx_25020047_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             o_imem_req_valid,
  input  logic             i_imem_req_ready,
  output logic [31:0]      o_imem_req_addr,
  input  logic             i_imem_rsp_valid,
  input  logic [31:0]      i_imem_rsp_data,
  output logic             o_inst_valid,
  input  logic             i_inst_ready,
  output logic [31:0]      o_inst,
  output logic [31:0]      o_inst_pc,
  input  logic             i_redirect_valid,
  input  logic [31:0]      i_redirect_pc,
  output logic             o_fetch_misalign,
  output logic [CNT_W-1:0] o_fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      w_pc_nxt;
  logic             r_kill;
  logic             w_kill_nxt;
  logic [31:0]      r_inst;
  logic [31:0]      r_inst_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load;
  logic             w_cnt_inc;
  logic             w_req_valid;
  logic             w_inst_valid;
  logic [31:0]      w_tgt;
  logic             w_tgt_bad;
  logic             w_lock;

`ifdef IFU_MISALIGN_CHECK_EN
  logic r_misalign;

  assign w_tgt            = i_redirect_pc;
  assign w_tgt_bad        = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
  assign w_lock           = r_misalign;
  assign o_fetch_misalign = r_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (w_tgt_bad) begin
      r_misalign <= 1'b1;
    end
  end
`else
  logic w_unused_lsb;

  // Low target bits are discarded so the PC stays word aligned.
  assign w_tgt            = {i_redirect_pc[31:2], 2'b00};
  assign w_unused_lsb     = ^i_redirect_pc[1:0];
  assign w_tgt_bad        = 1'b0;
  assign w_lock           = 1'b0;
  assign o_fetch_misalign = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_kill_nxt   = r_kill;
    w_load       = 1'b0;
    w_cnt_inc    = 1'b0;
    w_req_valid  = 1'b0;
    w_inst_valid = 1'b0;
    case (r_state)
      S_REQ: begin
        w_req_valid = ~i_redirect_valid & ~w_lock;
        if (i_redirect_valid) begin
          w_pc_nxt = w_tgt;
        end else if (w_req_valid && i_imem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_imem_rsp_valid) begin
          w_kill_nxt = 1'b0;
          if (i_redirect_valid) begin
            w_pc_nxt    = w_tgt;
            w_state_nxt = S_REQ;
          end else if (r_kill) begin
            w_state_nxt = S_REQ;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else if (i_redirect_valid) begin
          // The in-flight response still has to be drained; kill marks it stale.
          w_pc_nxt   = w_tgt;
          w_kill_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        w_inst_valid = 1'b1;
        w_cnt_inc    = i_inst_ready;
        if (i_redirect_valid) begin
          w_pc_nxt    = w_tgt;
          w_state_nxt = S_REQ;
        end else if (i_inst_ready) begin
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
    // A bad target parks the FSM in S_REQ with requests blocked until reset.
    if (w_tgt_bad) begin
      w_state_nxt = S_REQ;
      w_kill_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_kill    <= 1'b0;
      r_inst    <= 32'd0;
      r_inst_pc <= 32'd0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
      if (w_load) begin
        r_inst    <= i_imem_rsp_data;
        r_inst_pc <= r_pc;
      end
      if (w_cnt_inc) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_imem_req_valid = w_req_valid & ~rst;
  assign o_imem_req_addr  = r_pc;
  assign o_inst_valid     = w_inst_valid & ~rst;
  assign o_inst           = r_inst;
  assign o_inst_pc        = r_inst_pc;
  assign o_fetch_cnt      = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25020047_ifu.sv
// Directed, table-driven bench for ysyx_25020047_ifu with hand-written redirect/reset sequences.
`default_nettype none

module tb_ysyx_25020047_ifu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        misalign;
  logic [31:0] fcnt;

  int n_pass  = 0;
  int n_total = 0;

  ysyx_25020047_ifu #(.RESET_PC(32'h8000_0000), .CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .o_imem_req_valid (req_valid),
    .i_imem_req_ready (req_ready),
    .o_imem_req_addr  (req_addr),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .o_inst_valid     (inst_valid),
    .i_inst_ready     (inst_ready),
    .o_inst           (inst),
    .o_inst_pc        (inst_pc),
    .i_redirect_valid (redir_valid),
    .i_redirect_pc    (redir_pc),
    .o_fetch_misalign (misalign),
    .o_fetch_cnt      (fcnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] data;
    int          hold;
    logic [31:0] pc;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // From S_REQ at a negedge: issue request at pc, answer next cycle, land in S_HOLD.
  task automatic go_hold(input logic [31:0] pc, input logic [31:0] data);
    req_ready = 1'b1;
    #1;
    check("req_valid", {31'd0, req_valid}, 32'd1);
    check("req_addr", req_addr, pc);
    tick();
    req_ready = 1'b0;
    #1;
    check("wait_no_req", {31'd0, req_valid}, 32'd0);
    rsp_valid = 1'b1;
    rsp_data  = data;
    tick();
    rsp_valid = 1'b0;
    #1;
    check("inst_valid", {31'd0, inst_valid}, 32'd1);
    check("inst", inst, data);
    check("inst_pc", inst_pc, pc);
  endtask

  initial begin
    vecs[0] = '{data: 32'h0010_0093, hold: 0, pc: 32'h8000_0000, cnt: 32'd1};
    vecs[1] = '{data: 32'h0020_0113, hold: 5, pc: 32'h8000_0004, cnt: 32'd2};
    vecs[2] = '{data: 32'hDEAD_BEEF, hold: 1, pc: 32'h8000_0008, cnt: 32'd3};
    vecs[3] = '{data: 32'h0000_0013, hold: 0, pc: 32'h8000_000C, cnt: 32'd4};

    rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'd0;
    inst_ready = 1'b0; redir_valid = 1'b0; redir_pc = 32'd0;
    tick();
    tick();
    check("rst_req_valid", {31'd0, req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_addr", req_addr, 32'h8000_0000);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_cnt", fcnt, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    rst = 1'b0;

    // T1/T2: straight-line fetches, the second one stalled by the IDU.
    for (int i = 0; i < 4; i++) begin
      go_hold(vecs[i].pc, vecs[i].data);
      for (int h = 0; h < vecs[i].hold; h++) begin
        tick();
        #1;
        check("stall_inst", inst, vecs[i].data);
        check("stall_pc", inst_pc, vecs[i].pc);
        check("stall_no_req", {31'd0, req_valid}, 32'd0);
        check("stall_cnt", fcnt, vecs[i].cnt - 32'd1);
      end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      #1;
      check("hs_cnt", fcnt, vecs[i].cnt);
      check("hs_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("next_addr", req_addr, vecs[i].pc + 32'd4);
    end

    // T3: redirect while waiting; stale response must be dropped.
    req_ready = 1'b1;
    tick();
    req_ready   = 1'b0;
    redir_valid = 1'b1;
    redir_pc    = 32'h8000_0100;
    tick();
    redir_valid = 1'b0;
    for (int w = 0; w < 2; w++) begin
      tick();
      #1;
      check("t3_wait_no_inst", {31'd0, inst_valid}, 32'd0);
      check("t3_wait_no_req", {31'd0, req_valid}, 32'd0);
    end
    rsp_valid = 1'b1;
    rsp_data  = 32'hBAD0_BAD0;
    tick();
    rsp_valid = 1'b0;
    #1;
    check("t3_no_inst", {31'd0, inst_valid}, 32'd0);
    check("t3_req_valid", {31'd0, req_valid}, 32'd1);
    check("t3_req_addr", req_addr, 32'h8000_0100);

    // Response outside S_WAIT is ignored.
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    #1;
    check("ign_rsp_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("ign_rsp_req_valid", {31'd0, req_valid}, 32'd1);

    // Response and redirect in the same cycle.
    req_ready = 1'b1;
    tick();
    req_ready   = 1'b0;
    rsp_valid   = 1'b1;
    rsp_data    = 32'h1111_2222;
    redir_valid = 1'b1;
    redir_pc    = 32'h8000_0200;
    tick();
    rsp_valid   = 1'b0;
    redir_valid = 1'b0;
    #1;
    check("rr_no_inst", {31'd0, inst_valid}, 32'd0);
    check("rr_req_addr", req_addr, 32'h8000_0200);

    // Redirect in S_REQ suppresses the request that cycle.
    redir_valid = 1'b1;
    redir_pc    = 32'h8000_0300;
    #1;
    check("sreq_redir_no_req", {31'd0, req_valid}, 32'd0);
    tick();
    redir_valid = 1'b0;
    #1;
    check("sreq_redir_addr", req_addr, 32'h8000_0300);

    // T4: redirect coincident with handshake still counts.
    go_hold(32'h8000_0300, 32'h0030_0193);
    inst_ready  = 1'b1;
    redir_valid = 1'b1;
    redir_pc    = 32'h8000_0040;
    tick();
    inst_ready  = 1'b0;
    redir_valid = 1'b0;
    #1;
    check("t4_cnt", fcnt, 32'd5);
    check("t4_req_addr", req_addr, 32'h8000_0040);

    // Redirect without handshake drops the held instruction.
    go_hold(32'h8000_0040, 32'h0040_0213);
    redir_valid = 1'b1;
    redir_pc    = 32'h8000_0080;
    tick();
    redir_valid = 1'b0;
    #1;
    check("drop_cnt", fcnt, 32'd5);
    check("drop_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("drop_req_addr", req_addr, 32'h8000_0080);

    // T5: reset while holding.
    go_hold(32'h8000_0080, 32'h0050_0293);
    rst = 1'b1;
    tick();
    #1;
    check("t5_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("t5_req_valid", {31'd0, req_valid}, 32'd0);
    check("t5_cnt", fcnt, 32'd0);
    check("t5_addr", req_addr, 32'h8000_0000);
    rst = 1'b0;
    #1;
    check("t5_req_after", {31'd0, req_valid}, 32'd1);

    // T6: misaligned redirect target.
    redir_valid = 1'b1;
    redir_pc    = 32'h8000_0002;
    tick();
    redir_valid = 1'b0;
    req_ready   = 1'b1;
    #1;
`ifdef IFU_MISALIGN_CHECK_EN
    check("t6_misalign", {31'd0, misalign}, 32'd1);
    check("t6_no_req", {31'd0, req_valid}, 32'd0);
    tick();
    tick();
    #1;
    check("t6_still_no_req", {31'd0, req_valid}, 32'd0);
    check("t6_still_misalign", {31'd0, misalign}, 32'd1);
`else
    check("t6_misalign", {31'd0, misalign}, 32'd0);
    check("t6_req_valid", {31'd0, req_valid}, 32'd1);
    check("t6_req_addr", req_addr, 32'h8000_0000);
`endif
    req_ready = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
